// File: rtl/adc_scan_pkg.sv
// Shared constants and state types for the ADC round-robin scanner and its
// single-transaction Wishbone master.
package adc_scan_pkg;

  // SPI master register offsets, relative to its byte base address
  localparam logic [31:0] REG_DATA    = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS  = 32'h0000_0004;
  localparam logic [31:0] REG_CS      = 32'h0000_0008;
  localparam logic [31:0] REG_DIVISOR = 32'h0000_0030;

  // MCP3008 command framing: start byte, channel select byte, trailing pad
  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_PAD    = 8'h00;
  localparam logic [7:0] CS_ALL_OFF = 8'hFF;

  typedef enum logic [3:0] {
    ST_INIT_CS,
    ST_INIT_DIV,
    ST_IDLE,
    ST_CS_ON,
    ST_XFER_WR,
    ST_XFER_POLL,
    ST_XFER_RD,
    ST_STORE,
    ST_CS_OFF,
    ST_GAP
  } scan_state_e;

  typedef enum logic [1:0] {
    XS_IDLE,
    XS_ACTIVE,
    XS_RECOVER
  } xact_state_e;

  // Single-ended conversion request for one channel: SGL=1, D2..D0, four don't-care bits
  function automatic logic [7:0] cmd_select(input logic [2:0] ch);
    return {1'b1, ch, 4'h0};
  endfunction

endpackage

// File: rtl/wbm_xact.sv
// Single-transaction Wishbone master: takes one request, holds cyc/stb until
// ack or timeout, captures read data, then idles one cycle before the next.
module wbm_xact
  import adc_scan_pkg::*;
#(
  parameter logic [7:0] TMO_CYC = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdat_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        tmo_o,
  output logic [31:0] rdata_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic        m_ack_i
);

  xact_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;

  // Bus-facing state is fully registered so reset drops cyc/stb without waiting for a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= XS_IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  // Launch on request, finish on ack or after TMO_CYC unacked cycles, then one dead cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      XS_IDLE: begin
        if (req_i) begin
          state_d = XS_ACTIVE;
          cyc_d   = 1'b1;
          we_d    = we_i;
          adr_d   = adr_i;
          dat_d   = wdat_i;
          cnt_d   = '0;
        end
      end
      XS_ACTIVE: begin
        if (m_ack_i) begin
          cyc_d   = 1'b0;
          rdata_d = m_dat_i;
          done_d  = 1'b1;
          state_d = XS_RECOVER;
        end else if (cnt_q == TMO_CYC - 8'd1) begin
          cyc_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = XS_RECOVER;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      XS_RECOVER: state_d = XS_IDLE;
      default:    state_d = XS_IDLE;
    endcase
  end

  assign ready_o = (state_q == XS_IDLE);
  assign done_o  = done_q;
  assign tmo_o   = tmo_q;
  assign rdata_o = rdata_q;
  assign m_cyc_o = cyc_q;
  assign m_stb_o = cyc_q;
  assign m_we_o  = we_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;
  assign m_sel_o = cyc_q ? 4'hF : 4'h0;

endmodule

// File: rtl/wb_adc_scan.sv
// Round-robin MCP3008 scanner that drives the SPI master's register map over
// Wishbone and publishes the latest 10-bit sample for every channel.
module wb_adc_scan
  import adc_scan_pkg::*;
#(
  parameter logic [31:0] SPI_BASE = 32'h0000_0000,
  parameter int          N_CH     = 8,
  parameter int          CS_LINE  = 0,
  parameter logic [7:0]  SCK_DIV  = 8'd24,
  parameter logic [15:0] GAP_CYC  = 16'd1000,
  parameter logic [7:0]  TMO_CYC  = 8'd255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic [31:0]        m_adr_o,
  output logic [31:0]        m_dat_o,
  input  logic [31:0]        m_dat_i,
  output logic [3:0]         m_sel_o,
  output logic               m_cyc_o,
  output logic               m_stb_o,
  output logic               m_we_o,
  input  logic               m_ack_i,
  output logic               smp_valid,
  output logic [2:0]         smp_ch,
  output logic [9:0]         smp_data,
  output logic [N_CH*10-1:0] ch_data,
  output logic               scan_done,
  output logic               busy,
  output logic               err
);

  localparam logic [2:0] LAST_CH   = 3'(N_CH - 1);
  localparam logic [7:0] CS_SELECT = CS_ALL_OFF & ~(8'd1 << CS_LINE);

  scan_state_e       state_q, state_d;
  logic [2:0]        ch_q, ch_d;
  logic [1:0]        byte_q, byte_d;
  logic [1:0]        rx1_q, rx1_d;
  logic [7:0]        rx2_q, rx2_d;
  logic [15:0]       gap_q, gap_d;
  logic              launched_q, launched_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;
  logic              smp_valid_q, smp_valid_d;
  logic [2:0]        smp_ch_q, smp_ch_d;
  logic [9:0]        smp_data_q, smp_data_d;
  logic [N_CH*10-1:0] ch_data_q, ch_data_d;
  logic              scan_done_q, scan_done_d;
  logic              busy_q, busy_d;

  logic        x_req, x_we, x_ready, x_done, x_tmo;
  logic [31:0] x_adr, x_wdat, x_rdata;
  logic        unused_rdata;

  assign unused_rdata = ^x_rdata[31:8];

  wbm_xact #(.TMO_CYC(TMO_CYC)) u_xact (
    .clk     (clk),
    .reset   (reset),
    .req_i   (x_req),
    .we_i    (x_we),
    .adr_i   (x_adr),
    .wdat_i  (x_wdat),
    .ready_o (x_ready),
    .done_o  (x_done),
    .tmo_o   (x_tmo),
    .rdata_o (x_rdata),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_dat_i (m_dat_i),
    .m_sel_o (m_sel_o),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_we_o  (m_we_o),
    .m_ack_i (m_ack_i)
  );

  // Scan state, channel bookkeeping and published results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT_CS;
      ch_q        <= '0;
      byte_q      <= '0;
      rx1_q       <= '0;
      rx2_q       <= '0;
      gap_q       <= '0;
      launched_q  <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      smp_valid_q <= 1'b0;
      smp_ch_q    <= '0;
      smp_data_q  <= '0;
      ch_data_q   <= '0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      byte_q      <= byte_d;
      rx1_q       <= rx1_d;
      rx2_q       <= rx2_d;
      gap_q       <= gap_d;
      launched_q  <= launched_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      smp_valid_q <= smp_valid_d;
      smp_ch_q    <= smp_ch_d;
      smp_data_q  <= smp_data_d;
      ch_data_q   <= ch_data_d;
      scan_done_q <= scan_done_d;
      busy_q      <= busy_d;
    end
  end

  // Decode which register access the current state needs; requested once per state visit
  always_comb begin
    x_we   = 1'b1;
    x_adr  = SPI_BASE + REG_CS;
    x_wdat = {24'h0, CS_ALL_OFF};
    case (state_q)
      ST_INIT_DIV: begin
        x_adr  = SPI_BASE + REG_DIVISOR;
        x_wdat = {24'h0, SCK_DIV};
      end
      ST_CS_ON: x_wdat = {24'h0, CS_SELECT};
      ST_XFER_WR: begin
        x_adr = SPI_BASE + REG_DATA;
        case (byte_q)
          2'd0:    x_wdat = {24'h0, CMD_START};
          2'd1:    x_wdat = {24'h0, cmd_select(ch_q)};
          default: x_wdat = {24'h0, CMD_PAD};
        endcase
      end
      ST_XFER_POLL: begin
        x_we  = 1'b0;
        x_adr = SPI_BASE + REG_STATUS;
      end
      ST_XFER_RD: begin
        x_we  = 1'b0;
        x_adr = SPI_BASE + REG_DATA;
      end
      default: ;
    endcase
    x_req = !launched_q &&
            !(state_q inside {ST_IDLE, ST_STORE, ST_GAP});
  end

  // Next-state: walk the three SPI bytes per channel, store, release CS, then advance or rest
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    byte_d      = byte_q;
    rx1_d       = rx1_q;
    rx2_d       = rx2_q;
    gap_d       = gap_q;
    launched_d  = launched_q;
    abort_d     = abort_q;
    err_d       = err_q;
    smp_valid_d = 1'b0;
    smp_ch_d    = smp_ch_q;
    smp_data_d  = smp_data_q;
    ch_data_d   = ch_data_q;
    scan_done_d = 1'b0;

    if (x_req && x_ready) launched_d = 1'b1;
    if (x_done || x_tmo)  launched_d = 1'b0;

    case (state_q)
      ST_INIT_CS:  if (x_done) state_d = ST_INIT_DIV;
      ST_INIT_DIV: if (x_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_CS_ON;
          ch_d    = '0;
        end
      end
      ST_CS_ON: begin
        if (x_done) begin
          state_d = ST_XFER_WR;
          byte_d  = '0;
        end
      end
      ST_XFER_WR:   if (x_done) state_d = ST_XFER_POLL;
      ST_XFER_POLL: if (x_done && !x_rdata[0]) state_d = ST_XFER_RD;
      ST_XFER_RD: begin
        if (x_done) begin
          if (byte_q == 2'd1) rx1_d = x_rdata[1:0];
          if (byte_q == 2'd2) begin
            rx2_d   = x_rdata[7:0];
            state_d = ST_STORE;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = ST_XFER_WR;
          end
        end
      end
      ST_STORE: begin
        smp_valid_d = 1'b1;
        smp_ch_d    = ch_q;
        smp_data_d  = {rx1_q, rx2_q};
        ch_data_d[int'(ch_q)*10 +: 10] = {rx1_q, rx2_q};
        state_d     = ST_CS_OFF;
      end
      ST_CS_OFF: begin
        if (x_done) begin
          if (abort_q) begin
            abort_d = 1'b0;
            state_d = ST_IDLE;
          end else if (ch_q == LAST_CH) begin
            scan_done_d = 1'b1;
            gap_d       = '0;
            ch_d        = '0;
            state_d     = ST_GAP;
          end else if (enable) begin
            ch_d    = ch_q + 3'd1;
            state_d = ST_CS_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_CYC - 16'd1) begin
          ch_d    = '0;
          state_d = enable ? ST_CS_ON : ST_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (x_tmo) begin
      err_d = 1'b1;
      if (state_q == ST_CS_OFF) begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end else begin
        abort_d = 1'b1;
        state_d = ST_CS_OFF;
      end
    end

    busy_d = !(state_d inside {ST_IDLE, ST_GAP});
  end

  assign smp_valid = smp_valid_q;
  assign smp_ch    = smp_ch_q;
  assign smp_data  = smp_data_q;
  assign ch_data   = ch_data_q;
  assign scan_done = scan_done_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wb_adc_scan.sv
// Self-checking bench: wb_adc_scan against a behavioural SPI-master register
// file with an MCP3008 attached on chip select 0.
module tb_wb_adc_scan;

  localparam int N_CH = 8;
  localparam int GAP  = 1000;
  localparam int TMO  = 255;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [31:0]        m_adr_o;
  logic [31:0]        m_dat_o;
  logic [31:0]        m_dat_i = '0;
  logic [3:0]         m_sel_o;
  logic               m_cyc_o;
  logic               m_stb_o;
  logic               m_we_o;
  logic               m_ack_i = 1'b0;
  logic               smp_valid;
  logic [2:0]         smp_ch;
  logic [9:0]         smp_data;
  logic [N_CH*10-1:0] ch_data;
  logic               scan_done;
  logic               busy;
  logic               err;

  int testsRun    = 0;
  int testsFailed = 0;

  // Slave/ADC model state
  logic [9:0]  chVal [N_CH];
  bit          stallData = 1'b0;
  logic [7:0]  csReg = 8'hFF;
  int          frameIdx = 0;
  bit          frameOk = 1'b0;
  logic [9:0]  frameVal = '0;
  int          pollBusy = 0;
  logic [7:0]  misoByte = 8'hFF;
  int          lastCmdCh = -1;
  logic [31:0] wrAdr[$];
  logic [31:0] wrDat[$];

  // Monitor state
  int          smpCh[$];
  logic [9:0]  smpData[$];
  int          scanDoneCnt = 0;
  int          protoErr = 0;
  bit          prevAck = 1'b0;

  always #5 clk = ~clk;

  wb_adc_scan #(
    .SPI_BASE(32'h0000_0000), .N_CH(N_CH), .CS_LINE(0),
    .SCK_DIV(8'd24), .GAP_CYC(16'd1000), .TMO_CYC(8'd255)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_ack_i(m_ack_i),
    .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data), .ch_data(ch_data),
    .scan_done(scan_done), .busy(busy), .err(err)
  );

  // SPI master register file with a registered ack and an MCP3008 on CS bit 0
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_ack_i <= 1'b0;
      end else begin
        m_ack_i <= 1'b0;
        if (m_cyc_o && m_stb_o && !m_ack_i && !(stallData && m_we_o && m_adr_o == 32'h0)) begin
          m_ack_i <= 1'b1;
          if (m_we_o) begin
            wrAdr.push_back(m_adr_o);
            wrDat.push_back(m_dat_o);
            if (m_adr_o == 32'h8) begin
              csReg = m_dat_o[7:0];
              frameIdx = 0;
            end else if (m_adr_o == 32'h0) begin
              if (!csReg[0]) begin
                if (frameIdx == 0) begin
                  frameOk = (m_dat_o[7:0] == 8'h01);
                  misoByte = 8'($urandom);
                end else if (frameIdx == 1) begin
                  frameOk = frameOk && m_dat_o[7];
                  lastCmdCh = int'(m_dat_o[6:4]);
                  frameVal = frameOk ? chVal[lastCmdCh] : ~chVal[lastCmdCh];
                  misoByte = {6'($urandom), frameVal[9:8]};
                end else if (frameIdx == 2) begin
                  misoByte = frameVal[7:0];
                end else begin
                  misoByte = 8'hFF;
                end
                frameIdx++;
              end else begin
                misoByte = 8'hFF;
              end
              pollBusy = $urandom_range(0, 3);
            end
          end else begin
            if (m_adr_o == 32'h4) begin
              m_dat_i <= ($urandom() & 32'hFFFF_FFFE) | ((pollBusy > 0) ? 32'h1 : 32'h0);
              if (pollBusy > 0) pollBusy--;
            end else if (m_adr_o == 32'h0) begin
              m_dat_i <= {24'h0, misoByte};
            end else begin
              m_dat_i <= 32'h0;
            end
          end
        end
      end
    end
  end

  // Collect published samples and watch bus protocol on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (smp_valid) begin
          smpCh.push_back(int'(smp_ch));
          smpData.push_back(smp_data);
        end
        if (scan_done) scanDoneCnt++;
        if (m_stb_o && m_sel_o !== 4'hF) protoErr++;
        if (prevAck && m_cyc_o) protoErr++;
      end
      prevAck = m_ack_i;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int mode);
    for (int k = 0; k < N_CH; k++)
      chVal[k] = (mode == 1) ? 10'(100 * k) : 10'($urandom);
  endtask

  task automatic clearMonitors;
    smpCh.delete();
    smpData.delete();
    scanDoneCnt = 0;
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    int stable = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      stable = (!busy && !m_cyc_o) ? stable + 1 : 0;
      if (stable >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit got = 0;
    reset = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    testsRun++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_bus: cyc=%b stb=%b want 0 0", m_cyc_o, m_stb_o);
    end
    testsRun++;
    if (busy !== 1'b0 || err !== 1'b0 || smp_valid !== 1'b0 || scan_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: busy=%b err=%b valid=%b done=%b want 0", busy, err, smp_valid, scan_done);
    end
    testsRun++;
    if (ch_data !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_ch_data: got %h want 0", ch_data);
    end
    wrAdr.delete();
    wrDat.delete();
    reset = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = (wrAdr.size() >= 2);
    end
    testsRun++;
    if (!got) begin
      testsFailed++;
      $display("[TB] FAIL init_writes: got %0d writes want 2 within 100 cycles", wrAdr.size());
    end else begin
      testsRun++;
      if (wrAdr[0] !== 32'h8 || wrDat[0] !== 32'hFF) begin
        testsFailed++;
        $display("[TB] FAIL init_cs: adr=%h dat=%h want 00000008 000000ff", wrAdr[0], wrDat[0]);
      end
      if (wrAdr[1] !== 32'h30 || wrDat[1] !== 32'd24) begin
        testsFailed++;
        $display("[TB] FAIL init_div: adr=%h dat=%h want 00000030 00000018", wrAdr[1], wrDat[1]);
      end
    end
    repeat (30) tick();
    testsRun++;
    if (wrAdr.size() != 2 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL init_idle: writes=%0d busy=%b want 2 0", wrAdr.size(), busy);
    end
  endtask

  task automatic test_single_channel;
    bit ok;
    bit got = 0;
    applyStimulus(0);
    chVal[3] = 10'h2A5;
    clearMonitors();
    enable = 1'b1;
    for (int i = 0; i < 4000 && !got; i++) begin
      tick();
      got = (smpCh.size() >= 4);
    end
    testsRun++;
    if (!got) begin
      testsFailed++;
      $display("[TB] FAIL ch3_sample: got %0d samples want 4 within budget", smpCh.size());
    end else begin
      testsRun++;
      if (smpCh[3] != 3 || smpData[3] !== 10'h2A5) begin
        testsFailed++;
        $display("[TB] FAIL ch3_value: ch=%0d data=%h want 3 2a5", smpCh[3], smpData[3]);
      end
      testsRun++;
      if (ch_data[39:30] !== 10'h2A5) begin
        testsFailed++;
        $display("[TB] FAIL ch3_ch_data: got %h want 2a5", ch_data[39:30]);
      end
      testsRun++;
      if (smpData[1] !== chVal[1]) begin
        testsFailed++;
        $display("[TB] FAIL ch1_value: got %h want %h", smpData[1], chVal[1]);
      end
    end
    enable = 1'b0;
    waitIdle(2000, ok);
  endtask

  task automatic test_full_scan;
    bit ok;
    bit got = 0;
    int gapCnt = 0;
    logic [N_CH*10-1:0] expAll;
    applyStimulus(1);
    for (int k = 0; k < N_CH; k++) expAll[k*10 +: 10] = chVal[k];
    clearMonitors();
    enable = 1'b1;
    for (int i = 0; i < 8000 && !got; i++) begin
      tick();
      got = (scanDoneCnt >= 1);
    end
    testsRun++;
    if (!got) begin
      testsFailed++;
      $display("[TB] FAIL scan_done_seen: got %0d pulses want 1 within budget", scanDoneCnt);
    end else begin
      while (!m_cyc_o && gapCnt < GAP + 100) begin
        gapCnt++;
        tick();
      end
      testsRun++;
      if (gapCnt < GAP || gapCnt > GAP + 4) begin
        testsFailed++;
        $display("[TB] FAIL gap_length: got %0d idle cycles want %0d..%0d", gapCnt, GAP, GAP + 4);
      end
      testsRun++;
      if (m_adr_o !== 32'h8 || m_dat_o[7:0] !== 8'hFE) begin
        testsFailed++;
        $display("[TB] FAIL gap_next_cs_on: adr=%h dat=%h want 00000008 fe", m_adr_o, m_dat_o[7:0]);
      end
      testsRun++;
      if (smpCh.size() != N_CH || scanDoneCnt != 1) begin
        testsFailed++;
        $display("[TB] FAIL scan_count: samples=%0d done=%0d want %0d 1", smpCh.size(), scanDoneCnt, N_CH);
      end else begin
        for (int k = 0; k < N_CH; k++) begin
          testsRun++;
          if (smpCh[k] != k || smpData[k] !== chVal[k]) begin
            testsFailed++;
            $display("[TB] FAIL scan_sample%0d: ch=%0d data=%0d want %0d %0d", k, smpCh[k], smpData[k], k, chVal[k]);
          end
        end
      end
      testsRun++;
      if (ch_data !== expAll) begin
        testsFailed++;
        $display("[TB] FAIL scan_ch_data: got %h want %h", ch_data, expAll);
      end
    end
    enable = 1'b0;
    waitIdle(2000, ok);
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit got = 0;
    applyStimulus(0);
    clearMonitors();
    enable = 1'b1;
    for (int i = 0; i < 14000 && !got; i++) begin
      tick();
      got = (scanDoneCnt >= 2);
    end
    enable = 1'b0;
    testsRun++;
    if (!got || smpCh.size() < 2 * N_CH) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: done=%0d samples=%0d want 2 %0d", scanDoneCnt, smpCh.size(), 2 * N_CH);
    end else begin
      for (int i = 0; i < 2 * N_CH; i++) begin
        testsRun++;
        if (smpCh[i] != i % N_CH || smpData[i] !== chVal[i % N_CH]) begin
          testsFailed++;
          $display("[TB] FAIL b2b_sample%0d: ch=%0d data=%h want %0d %h", i, smpCh[i], smpData[i], i % N_CH, chVal[i % N_CH]);
        end
      end
    end
    testsRun++;
    if (err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_err: got %b want 0", err);
    end
    waitIdle(2000, ok);
  endtask

  task automatic test_enable_drop;
    bit ok;
    bit got = 0;
    int mark;
    int csOnAfter = 0;
    applyStimulus(0);
    clearMonitors();
    lastCmdCh = -1;
    enable = 1'b1;
    for (int i = 0; i < 4000 && !got; i++) begin
      tick();
      got = (lastCmdCh == 2);
    end
    enable = 1'b0;
    mark = wrAdr.size();
    waitIdle(1000, ok);
    testsRun++;
    if (!got || !ok) begin
      testsFailed++;
      $display("[TB] FAIL drop_reach: ch2_seen=%0d idle=%0d want 1 1", got, ok);
    end else begin
      for (int i = mark; i < wrAdr.size(); i++)
        if (wrAdr[i] == 32'h8 && wrDat[i][7:0] == 8'hFE) csOnAfter++;
      testsRun++;
      if (smpCh.size() != 3 || smpCh[2] != 2 || smpData[2] !== chVal[2]) begin
        testsFailed++;
        $display("[TB] FAIL drop_ch2: samples=%0d want 3 ending ch2=%h", smpCh.size(), chVal[2]);
      end
      testsRun++;
      if (csOnAfter != 0 || csReg !== 8'hFF) begin
        testsFailed++;
        $display("[TB] FAIL drop_no_ch3: cs_on_after=%0d cs=%h want 0 ff", csOnAfter, csReg);
      end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    bit got = 0;
    int hiCnt = 0;
    applyStimulus(0);
    clearMonitors();
    stallData = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      tick();
      got = (m_cyc_o && m_we_o && m_adr_o == 32'h0);
    end
    while (got && m_cyc_o && hiCnt < 400) begin
      hiCnt++;
      tick();
    end
    repeat (3) tick();
    testsRun++;
    if (!got || hiCnt != TMO) begin
      testsFailed++;
      $display("[TB] FAIL tmo_length: cyc held %0d cycles want %0d", hiCnt, TMO);
    end
    testsRun++;
    if (err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL tmo_err: got %b want 1", err);
    end
    enable = 1'b0;
    stallData = 1'b0;
    waitIdle(500, ok);
    testsRun++;
    if (!ok || csReg !== 8'hFF || smpCh.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL tmo_recover: idle=%0d cs=%h samples=%0d want 1 ff 0", ok, csReg, smpCh.size());
    end
    testsRun++;
    if (err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL tmo_sticky: got %b want 1", err);
    end
  endtask

  task automatic test_reset_mid_poll;
    bit ok;
    bit got = 0;
    enable = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      tick();
      got = (m_cyc_o && !m_we_o && m_adr_o == 32'h4);
    end
    testsRun++;
    if (!got) begin
      testsFailed++;
      $display("[TB] FAIL poll_seen: no STATUS read within budget");
    end
    #2;
    reset = 1'b0;
    #1;
    testsRun++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_drop: cyc=%b stb=%b want 0 0", m_cyc_o, m_stb_o);
    end
    testsRun++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_flags: err=%b busy=%b want 0 0", err, busy);
    end
    enable = 1'b0;
    wrAdr.delete();
    wrDat.delete();
    repeat (3) tick();
    reset = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = (wrAdr.size() >= 2);
    end
    testsRun++;
    if (!got || wrAdr[0] !== 32'h8 || wrDat[0] !== 32'hFF || wrAdr[1] !== 32'h30 || wrDat[1] !== 32'd24) begin
      testsFailed++;
      $display("[TB] FAIL reinit: writes=%0d want CS=ff then DIVISOR=24", wrAdr.size());
    end
    waitIdle(200, ok);
  endtask

  task automatic test_protocol;
    testsRun++;
    if (protoErr !== 0) begin
      testsFailed++;
      $display("[TB] FAIL wb_protocol: %0d violations want 0", protoErr);
    end
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < N_CH; k++) chVal[k] = '0;
    test_reset();
    test_single_channel();
    test_full_scan();
    test_back_to_back();
    test_enable_drop();
    test_timeout();
    test_reset_mid_poll();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
